// File: rtl/fpu_share_arbiter.sv
// fpu_share_arbiter: round-robin time-sharing of one stb/ack FP core among N requesters.
module fpu_share_arbiter #(
  parameter int N  = 4,
  parameter int W  = 64,
  parameter int GW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_valid,
  input  logic [N*W-1:0]  req_a,
  input  logic [N*W-1:0]  req_b,
  output logic [N-1:0]    req_ready,
  output logic [N-1:0]    rsp_valid,
  output logic [W-1:0]    rsp_data,
  input  logic [N-1:0]    rsp_ready,
  output logic [W-1:0]    u_input_a,
  output logic            u_input_a_stb,
  input  logic            u_input_a_ack,
  output logic [W-1:0]    u_input_b,
  output logic            u_input_b_stb,
  input  logic            u_input_b_ack,
  input  logic [W-1:0]    u_output_z,
  input  logic            u_output_z_stb,
  output logic            u_output_z_ack,
  output logic            busy,
  output logic [GW-1:0]   grant_id
);
  typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, WAIT_Z, RESP} state_t;
  state_t state;
  logic [GW-1:0] last_grant, pick;
  logic [W-1:0] a_q, b_q;
  logic found;
  // descending scan: the offset nearest last_grant+1 is written last and wins
  always_comb begin
    pick = '0;
    found = 1'b0;
    for (int i = N; i >= 1; i--) begin
      if (req_valid[(int'(last_grant) + i) % N]) begin
        pick = GW'((int'(last_grant) + i) % N);
        found = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      last_grant     <= GW'(N - 1);
      grant_id       <= '0;
      req_ready      <= '0;
      rsp_valid      <= '0;
      rsp_data       <= '0;
      a_q            <= '0;
      b_q            <= '0;
      u_input_a_stb  <= 1'b0;
      u_input_b_stb  <= 1'b0;
      u_output_z_ack <= 1'b0;
      busy           <= 1'b0;
    end else begin
      req_ready      <= '0;
      u_output_z_ack <= 1'b0;
      case (state)
        IDLE: if (found) begin
          a_q             <= req_a[int'(pick)*W +: W];
          b_q             <= req_b[int'(pick)*W +: W];
          req_ready       <= N'(1) << pick;
          grant_id        <= pick;
          u_input_a_stb   <= 1'b1;
          busy            <= 1'b1;
          state           <= SEND_A;
        end
        SEND_A: if (u_input_a_stb && u_input_a_ack) begin
          u_input_a_stb <= 1'b0;
          u_input_b_stb <= 1'b1;
          state         <= SEND_B;
        end
        SEND_B: if (u_input_b_stb && u_input_b_ack) begin
          u_input_b_stb <= 1'b0;
          state         <= WAIT_Z;
        end
        WAIT_Z: if (u_output_z_stb) begin
          rsp_data       <= u_output_z;
          u_output_z_ack <= 1'b1;
          rsp_valid      <= N'(1) << grant_id;
          state          <= RESP;
        end
        RESP: if (rsp_ready[grant_id]) begin
          rsp_valid  <= '0;
          last_grant <= grant_id;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign u_input_a = a_q;
  assign u_input_b = b_q;
endmodule

// File: doc/fpu_share_arbiter.md
# fpu_share_arbiter

Round-robin arbiter that time-shares one double-precision floating-point unit (double_divider, double_multiplier or double_adder, all using the same stb/ack handshake) among N requesters. It sits between the LU-decomposition sequencer lanes and a single FP core, so several datapath lanes can use one instance instead of one core per lane. Each accepted request runs as one complete transaction: operand A, operand B, result. The result is returned only to the granted requester.

## Interface
Parameters:
- N, 4, number of requesters (2..8)
- W, 64, operand/result width (IEEE-754 double)
- GW, $clog2(N), grant index width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
- req_valid  in  N  per-requester operation request
- req_a  in  N*W  operand A, requester i at [i*W +: W]
- req_b  in  N*W  operand B, same packing
- req_ready  out  N  one-cycle one-hot pulse: request i accepted, operands captured
- rsp_valid  out  N  one-hot: result available for requester i
- rsp_data  out  W  result, valid while any rsp_valid bit is high
- rsp_ready  in  N  requester i consumes result
- u_input_a  out  W  FP core operand A
- u_input_a_stb  out  1  FP core operand A strobe
- u_input_a_ack  in  1  FP core operand A acknowledge
- u_input_b  out  W  FP core operand B
- u_input_b_stb  out  1  FP core operand B strobe
- u_input_b_ack  in  1  FP core operand B acknowledge
- u_output_z  in  W  FP core result
- u_output_z_stb  in  1  FP core result strobe
- u_output_z_ack  out  1  FP core result acknowledge
- busy  out  1  high in every state except IDLE
- grant_id  out  GW  index of the current or last granted requester

## Operation
- States: IDLE, SEND_A, SEND_B, WAIT_Z, RESP.
- **IDLE**
  - If any req_valid bit is set, select the winner round-robin: the first set bit searching upward from last_grant+1, with wrap.
  - Capture req_a and req_b of the winner into internal registers.
  - Pulse req_ready[winner] for one cycle and set grant_id to the winner.
  - Assert u_input_a_stb and go to SEND_A.
- **SEND_A**
  - u_input_a = captured A; hold the strobe.
  - On u_input_a_stb && u_input_a_ack: drop u_input_a_stb, assert u_input_b_stb, go to SEND_B.
- **SEND_B**
  - u_input_b = captured B; hold the strobe.
  - On ack: drop u_input_b_stb, go to WAIT_Z.
- **WAIT_Z**
  - On u_output_z_stb: register u_output_z into rsp_data.
  - Assert u_output_z_ack for exactly one cycle, set rsp_valid[grant_id], go to RESP.
- **RESP**
  - Hold rsp_valid and rsp_data stable until rsp_ready[grant_id] is high.
  - Then clear rsp_valid, set last_grant = grant_id, go to IDLE.
- rsp_ready bits of non-granted requesters are ignored.
- A requester may drop req_valid before it is granted; there is no side effect.
- After req_ready, the requester's req_a/req_b may change freely, because operands are registered.
- u_output_z_stb outside WAIT_Z is ignored. The FP core cannot produce it outside WAIT_Z under correct protocol.
- The arbiter does no arithmetic. Data passes through bit-exact.

## Timing
- **Reset (rst=0, asynchronous):**
  - All outputs are 0: req_ready, rsp_valid, rsp_data, all strobes, u_output_z_ack, busy, grant_id.
  - State = IDLE; last_grant = N-1, so requester 0 wins first.
  - The shared FP core receives the same reset.
- **Reset mid-transaction:** strobes and rsp_valid drop immediately. The transaction is lost and no response is issued.
- **Grant latency:** req_ready pulses in the cycle after req_valid is sampled in IDLE. u_input_a_stb is high in that same cycle.
- **Core handshakes:** each takes at least one cycle per state. Total requester-visible latency is 4 + core compute cycles + core ack delays.
- **Back-to-back:** the rsp_ready handshake cycle returns to IDLE. The next grant is issued one cycle later, so there is one bubble between transactions.
- **Fairness:** with all N requesters continuously valid, grants rotate 0,1,…,N-1,0. No requester waits more than N-1 transactions.
- busy rises with req_ready and falls in the cycle IDLE is re-entered.

## Test plan
- **Single multiply:** requester 2 sends A=0x4000000000000000 (2.0), B=0x4008000000000000 (3.0) into a double_multiplier.
  - Expect req_ready=4'b0100 for one cycle, then rsp_valid=4'b0100 with rsp_data=0x4018000000000000 (6.0).
  - Expect u_output_z_ack high exactly one cycle.
- **All four requesters valid from reset:** grant order 0,1,2,3,0. Each rsp_data matches its own operands, with a one-cycle bubble between rsp_ready and the next req_ready.
- **Slow ack:** hold u_input_a_ack low for 5 cycles, then high.
  - u_input_a_stb and u_input_a stay stable throughout; u_input_b_stb is not asserted before the A handshake completes.
- **Response backpressure:** keep rsp_ready low for 10 cycles in RESP.
  - rsp_valid and rsp_data stay stable, no new grant is issued, and busy stays 1.
  - rsp_ready from a non-granted requester does not complete the transaction.
- **Reset during WAIT_Z:** drive rst=0 mid-transaction.
  - Outputs go to 0 asynchronously and no rsp_valid appears afterward.
  - After release, requester 0 is granted first.
- **Withdrawn request:** requester 1 pulses req_valid for one cycle while the arbiter is busy.
  - No req_ready[1] is ever issued, and the next grant goes to the next valid requester.
